// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-index width,
// default divide latency and the divide-timer state encoding.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W          = 4;
  localparam int DIV_LATENCY_DEFAULT = 8;

  typedef logic [0:0] div_state_t;

  localparam div_state_t ST_RUN      = 1'b0;
  localparam div_state_t ST_DIV_BUSY = 1'b1;

endpackage

// File: rtl/div_busy_timer.sv
// Divide occupancy timer: holds EX busy for DIV_LATENCY-1 cycles after a
// divide is accepted into EX.
module div_busy_timer #(
  parameter int DIV_LATENCY = pipeline_ctrl_pkg::DIV_LATENCY_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);
  import pipeline_ctrl_pkg::*;

  div_state_t state;
  logic [7:0] div_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_RUN;
      div_cnt <= 8'd0;
    end else begin
      case (state)
        ST_RUN: begin
          if (start) begin
            state   <= ST_DIV_BUSY;
            div_cnt <= 8'(DIV_LATENCY - 1);
          end
        end
        default: begin
          if (div_cnt == 8'd1) begin
            state   <= ST_RUN;
            div_cnt <= 8'd0;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
      endcase
    end
  end

  assign busy = (state == ST_DIV_BUSY);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline stall/flush controller: load-use interlock, taken-branch flush and
// multi-cycle divide occupancy of EX, plus a saturating stall counter.
module pipeline_hazard_controller #(
  parameter int DIV_LATENCY = pipeline_ctrl_pkg::DIV_LATENCY_DEFAULT,
  parameter int REG_ADDR_W  = pipeline_ctrl_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  of_valid,
  input  logic [REG_ADDR_W-1:0] of_rs1,
  input  logic [REG_ADDR_W-1:0] of_rs2,
  input  logic                  of_use_rs1,
  input  logic                  of_use_rs2,
  input  logic [REG_ADDR_W-1:0] of_rd,
  input  logic                  of_writes_rd,
  input  logic                  of_is_load,
  input  logic                  of_is_div,
  input  logic                  is_Branch_Taken,
  output logic                  pc_en,
  output logic                  if_of_en,
  output logic                  if_of_flush,
  output logic                  of_ex_bubble,
  output logic                  ex_busy,
  output logic [15:0]           stall_cycles
);
  import pipeline_ctrl_pkg::*;

  logic                  ex_valid;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_writes_rd;
  logic                  ex_is_load;

  logic run;
  logic load_use;
  logic div_start;

  assign run = ~ex_busy;

  assign load_use = run & of_valid & ex_valid & ex_is_load & ex_writes_rd &
                    ((of_use_rs1 & (of_rs1 == ex_rd)) |
                     (of_use_rs2 & (of_rs2 == ex_rd)));

  // A divide is only accepted when it actually moves into EX this edge.
  assign div_start = run & of_valid & of_is_div & ~of_ex_bubble;

  div_busy_timer #(
    .DIV_LATENCY (DIV_LATENCY)
  ) u_div_busy_timer (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .busy  (ex_busy)
  );

  // NOTE: every output gets a default first so no path through the block can
  // leave a value unassigned and infer a latch.
  always_comb begin
    pc_en        = 1'b1;
    if_of_en     = 1'b1;
    if_of_flush  = 1'b0;
    of_ex_bubble = 1'b0;
    if (!reset) begin
      pc_en        = 1'b0;
      if_of_en     = 1'b0;
      if_of_flush  = 1'b1;
      of_ex_bubble = 1'b1;
    end else if (ex_busy) begin
      pc_en    = 1'b0;
      if_of_en = 1'b0;
    end else if (is_Branch_Taken) begin
      // Redirect wins over a load-use stall: the dependent instruction is squashed.
      if_of_flush  = 1'b1;
      of_ex_bubble = 1'b1;
    end else if (load_use) begin
      pc_en        = 1'b0;
      if_of_en     = 1'b0;
      of_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_rd        <= '0;
      ex_writes_rd <= 1'b0;
      ex_is_load   <= 1'b0;
    end else if (run) begin
      ex_valid     <= of_valid & ~of_ex_bubble;
      ex_rd        <= of_rd;
      ex_writes_rd <= of_writes_rd;
      ex_is_load   <= of_is_load;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 16'd0;
    end else if (!pc_en && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter DIV_LATENCY, default 8: number of cycles a div/mod instruction occupies EX (legal range 2..255).
REQ-002 SHALL have parameter REG_ADDR_W, default 4: register-index width (16 architectural registers).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port of_valid, input, 1: OF stage holds a real instruction.
REQ-006 SHALL have ports of_rs1 and of_rs2, input, REG_ADDR_W each: OF source registers.
REQ-007 SHALL have ports of_use_rs1 and of_use_rs2, input, 1 each: OF instruction reads that source.
REQ-008 SHALL have ports of_rd (input, REG_ADDR_W) and of_writes_rd (input, 1): OF destination register and its write flag.
REQ-009 SHALL have ports of_is_load and of_is_div, input, 1 each: OF instruction is ld, or is div/mod.
REQ-010 SHALL have port is_Branch_Taken, input, 1: EX resolved a taken branch, call or ret this cycle.
REQ-011 SHALL have port pc_en, output, 1: PC register load enable.
REQ-012 SHALL have port if_of_en, output, 1: IF/OF latch enable.
REQ-013 SHALL have port if_of_flush, output, 1: IF/OF latch loads a NOP.
REQ-014 SHALL have port of_ex_bubble, output, 1: OF/EX latch loads a NOP instead of the OF instruction.
REQ-015 SHALL have port ex_busy, output, 1: multi-cycle divide occupies EX; EX/MA latch loads a NOP.
REQ-016 SHALL have port stall_cycles, output, 16: saturating count of cycles with pc_en=0 since reset.

Function
REQ-017 SHALL track the instruction in EX: ex_valid, ex_rd, ex_writes_rd, ex_is_load, captured from OF inputs on every edge where the FSM is RUN.
REQ-018 A bubble (of_ex_bubble=1 or of_valid=0) SHALL capture ex_valid=0.
REQ-019 SHALL implement a two-state FSM, RUN and DIV_BUSY, with an 8-bit down-counter div_cnt.
REQ-020 Load-use hazard = RUN & of_valid & ex_valid & ex_is_load & ex_writes_rd & ((of_use_rs1 & of_rs1==ex_rd) | (of_use_rs2 & of_rs2==ex_rd)).
REQ-021 On a load-use hazard SHALL drive pc_en=0, if_of_en=0, of_ex_bubble=1 for exactly one cycle; the next cycle re-evaluates with ex_valid=0.
REQ-022 On is_Branch_Taken in RUN SHALL drive pc_en=1, if_of_en=1, if_of_flush=1 and of_ex_bubble=1 in the same cycle.
REQ-023 Branch SHALL take priority over a simultaneous load-use hazard: no stall is produced.
REQ-024 RUN->DIV_BUSY SHALL occur when RUN, of_valid, of_is_div and no bubble are true at a clock edge; div_cnt loads DIV_LATENCY-1.
REQ-025 In DIV_BUSY SHALL drive pc_en=0, if_of_en=0, of_ex_bubble=0, ex_busy=1 and hold all EX-tracking registers.
REQ-026 In DIV_BUSY div_cnt SHALL decrement each cycle; at div_cnt==1 the FSM SHALL return to RUN, so ex_busy lasts DIV_LATENCY-1 cycles.
REQ-027 is_Branch_Taken SHALL be ignored in DIV_BUSY.
REQ-028 In RUN with no hazard and no branch SHALL drive pc_en=1, if_of_en=1, if_of_flush=0, of_ex_bubble=0, ex_busy=0.
REQ-029 All outputs SHALL be combinational from the current inputs and registered state (zero-cycle latency).
REQ-030 stall_cycles SHALL increment on each edge where pc_en=0 and reset is deasserted, and SHALL saturate at 16'hFFFF.

Reset
REQ-031 While reset=0 SHALL hold state=RUN, div_cnt=0, ex_valid=0, stall_cycles=0.
REQ-032 While reset=0 SHALL drive pc_en=0, if_of_en=0, if_of_flush=1, of_ex_bubble=1, ex_busy=0.
REQ-033 Reset asserted mid-divide SHALL immediately abort to RUN without waiting for a clock.
REQ-034 The first edge after reset release SHALL behave as RUN with ex_valid=0.

Structure
REQ-035 Shared package pipeline_ctrl_pkg SHALL hold the FSM state type, REG_ADDR_W and the default DIV_LATENCY.
REQ-036 The divide timer (FSM plus div_cnt) SHALL be one sub-module, div_busy_timer; hazard and branch logic stay in the top level.

Verification
REQ-037 Load-use: ld r3 in EX, OF add r5,r3,r2 (use_rs1, rs1=3) -> one cycle pc_en=0, if_of_en=0, of_ex_bubble=1; next cycle all enables 1; stall_cycles=1.
REQ-038 No false stall: ld r3 in EX, OF reads only r4; or add r3 in EX, OF reads r3 -> pc_en stays 1, of_ex_bubble=0.
REQ-039 Branch: is_Branch_Taken=1 together with a load-use hazard -> pc_en=1, if_of_flush=1, of_ex_bubble=1, stall_cycles unchanged.
REQ-040 Divide: div enters EX with DIV_LATENCY=8 -> ex_busy=1 and pc_en=0 for 7 cycles, is_Branch_Taken pulse ignored, then RUN; stall_cycles=7.
REQ-041 Reset mid-divide at busy cycle 3 -> outputs take reset values immediately, stall_cycles=0; after release, normal RUN.
REQ-042 Saturation: force 70000 stall cycles -> stall_cycles holds 16'hFFFF.
